noc_out_port_arbiter: RTL and testbench
=======================================

Name: noc_out_port_arbiter

Overview:
- Round-robin arbiter and sequencer for one router output port, shared by the three input FIFOs (x, y, local) of the 40-bit flit router pipeline.
- Selects a head flit whose destination code matches this port, then pops the source FIFO.
- Registers the flit and forwards it downstream under next-hop backpressure.
- Instantiated once per output port, each instance with a different DEST_CODE.

Parameters:
- WD, 40, flit width; destination code is flit[WD-1:WD-4].
- DEST_CODE, 4'b0100, code steered to this port (0100 x, 1000 y, 0010 local).
- STALL_LIMIT, 15, consecutive backpressured cycles that set stall_err.

Ports:
- wclk  in  1  clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- empty_x, empty_y, empty_local  in  1 each  source FIFO empty.
- head_x, head_y, head_local  in  WD each  source FIFO head flit (first-word-fall-through, valid while !empty).
- rd_en_x, rd_en_y, rd_en_local  out  1 each  registered one-cycle pop pulse.
- next_full  in  1  downstream FIFO full.
- data_out  out  WD  flit to downstream.
- wr_next_en  out  1  one-cycle downstream write strobe.
- grant  out  3  one-hot {local,y,x} of last winner.
- busy  out  1  high in SEND state.
- flit_cnt  out  16  flits forwarded, wraps 0xFFFF->0.
- stall_err  out  1  sticky backpressure timeout.

Behaviour:
- Reset (rst_n=0 at posedge) clears all outputs to 0: data_out, rd_en_*, wr_next_en, grant, busy, flit_cnt, stall_err. State goes to IDLE, pointer ptr goes to x, stall counter goes to 0.
- Reset mid-SEND discards the held flit; the source pop has already happened, so the flit is lost, by design.
- Request: req_i = !empty_i && head_i[WD-1:WD-4]==DEST_CODE.
- Priority:
  - Fixed order x=0, y=1, local=2, rotated so that ptr has highest priority.
  - After a grant to i, ptr <= (i+1) mod 3.
  - ptr is unchanged when there is no grant.
- FSM, 2 states:
  - IDLE, no request: rd_en_* <= 0, wr_next_en <= 0.
  - IDLE, any request: winner w is latched. data_out <= head_w, rd_en_w <= 1, grant <= onehot(w), busy <= 1, state <= SEND. wr_next_en <= 0.
  - SEND: rd_en_* <= 0. The FIFO pops during this cycle.
  - SEND with next_full=0: wr_next_en <= 1, flit_cnt <= flit_cnt+1, stall counter <= 0, busy <= 0, state <= IDLE.
  - SEND with next_full=1: hold data_out. Stall counter increments, saturating. When it reaches STALL_LIMIT, stall_err <= 1 and stays set until reset. Remain in SEND.
- Timing and throughput:
  - data_out is stable for the whole cycle in which wr_next_en=1.
  - A new grant may be made in that same IDLE cycle; data_out changes on the edge that ends it.
  - Peak throughput is 1 flit per 2 cycles.
  - Latency from request seen to wr_next_en high is 2 cycles with no backpressure.
- Heads are never sampled in SEND; the post-pop head is evaluated in the following IDLE cycle.
- Non-matching heads are ignored; they never block other requesters.
- Exactly one rd_en is high per grant, and never two consecutive cycles.
- next_full toggling during SEND simply extends SEND; no flit is duplicated or dropped.

Test Plan:
- Reset then only x holds 3 matching flits (0x40_0000_0001..3):
  - Required: rd_en_x pulses at cycles 1, 3, 5.
  - Required: wr_next_en at cycles 2, 4, 6 with data_out 0x4000000001, 0x4000000002, 0x4000000003.
  - Required: flit_cnt = 3.
- x, y, local all hold matching flits continuously (DEST_CODE=0100 on all heads):
  - Required: grant sequence 001, 010, 100, 001, …
  - Required: no requester is granted twice in a row while the others request.
- x head 0x80_0000_0001 (code 1000), y head 0x40_0000_0005:
  - Required: x is never popped; only y is granted, data_out = 0x4000000005.
- next_full=1 for 4 cycles during SEND:
  - Required: data_out held, busy=1, no wr_next_en.
  - Required: after release, a single wr_next_en and flit_cnt +1.
- next_full held 20 cycles in SEND:
  - Required: stall_err rises exactly 15 cycles after entering the stall and stays 1 after release, until rst_n=0.
- rst_n=0 asserted during SEND:
  - Required: the next cycle has all outputs 0 and ptr=x.
  - Required: the next grant goes to x when x, y and local all request.

Source files
------------

// File: rtl/noc_out_port_arbiter.sv
// Round-robin arbiter/sequencer for one router output port.
// Picks a matching head flit from the x, y or local input FIFO, pops it,
// registers it and forwards it downstream under next-hop backpressure.
module noc_out_port_arbiter #(
    parameter int unsigned WD          = 40,
    parameter logic [3:0]  DEST_CODE   = 4'b0100,
    parameter int unsigned STALL_LIMIT = 15
) (
    input  logic          wclk,
    input  logic          rst_n,
    input  logic          empty_x,
    input  logic          empty_y,
    input  logic          empty_local,
    input  logic [WD-1:0] head_x,
    input  logic [WD-1:0] head_y,
    input  logic [WD-1:0] head_local,
    output logic          rd_en_x,
    output logic          rd_en_y,
    output logic          rd_en_local,
    input  logic          next_full,
    output logic [WD-1:0] data_out,
    output logic          wr_next_en,
    output logic [2:0]    grant,
    output logic          busy,
    output logic [15:0]   flit_cnt,
    output logic          stall_err
);

    localparam int unsigned SW = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state;
    logic [1:0]      ptr;
    logic [SW-1:0]   stall_cnt;

    logic [2:0]      req_c;
    logic            win_vld_c;
    logic [1:0]      win_idx_c;
    logic [WD-1:0]   win_head_c;

    // Source index offset positions away from base, modulo 3.
    function automatic logic [1:0] rot_idx(input logic [1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= 3) begin
            sum = sum - 3;
        end
        return 2'(sum);
    endfunction

    // A source requests when it has a head flit steered to this port.
    always_comb begin
        req_c    = '0;
        req_c[0] = !empty_x     && (head_x[WD-1 -: 4]     == DEST_CODE);
        req_c[1] = !empty_y     && (head_y[WD-1 -: 4]     == DEST_CODE);
        req_c[2] = !empty_local && (head_local[WD-1 -: 4] == DEST_CODE);
    end

    // Rotated-priority pick: scan lowest to highest so ptr's slot wins last.
    always_comb begin
        win_vld_c = 1'b0;
        win_idx_c = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (req_c[rot_idx(ptr, k)]) begin
                win_vld_c = 1'b1;
                win_idx_c = rot_idx(ptr, k);
            end
        end
    end

    // Head flit of the selected source.
    always_comb begin
        win_head_c = head_x;
        case (win_idx_c)
            2'd1:    win_head_c = head_y;
            2'd2:    win_head_c = head_local;
            default: win_head_c = head_x;
        endcase
    end

    // Grant/forward sequencer with registered outputs and stall watchdog.
    always_ff @(posedge wclk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            stall_cnt   <= '0;
            data_out    <= '0;
            rd_en_x     <= 1'b0;
            rd_en_y     <= 1'b0;
            rd_en_local <= 1'b0;
            wr_next_en  <= 1'b0;
            grant       <= 3'b000;
            busy        <= 1'b0;
            flit_cnt    <= 16'd0;
            stall_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wr_next_en  <= 1'b0;
                    rd_en_x     <= win_vld_c && (win_idx_c == 2'd0);
                    rd_en_y     <= win_vld_c && (win_idx_c == 2'd1);
                    rd_en_local <= win_vld_c && (win_idx_c == 2'd2);
                    if (win_vld_c) begin
                        data_out <= win_head_c;
                        grant    <= 3'b001 << win_idx_c;
                        busy     <= 1'b1;
                        ptr      <= rot_idx(win_idx_c, 1);
                        state    <= SEND;
                    end
                end
                SEND: begin
                    rd_en_x     <= 1'b0;
                    rd_en_y     <= 1'b0;
                    rd_en_local <= 1'b0;
                    if (!next_full) begin
                        wr_next_en <= 1'b1;
                        flit_cnt   <= flit_cnt + 16'd1;
                        stall_cnt  <= '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        wr_next_en <= 1'b0;
                        if (stall_cnt != SW'(STALL_LIMIT)) begin
                            stall_cnt <= stall_cnt + SW'(1);
                        end
                        if (32'(stall_cnt) + 32'd1 >= STALL_LIMIT) begin
                            stall_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Bench for noc_out_port_arbiter: FIFO models feed the three sources, a
// reference model predicts every registered output each cycle, and directed
// steps check the headline behaviours with constant expectations.
module tb_noc_out_port_arbiter;

    localparam int unsigned WD = 40;
    localparam logic [3:0] DEST = 4'b0100;

    logic          wclk;
    logic          rst_n;
    logic          empty_x, empty_y, empty_local;
    logic [WD-1:0] head_x, head_y, head_local;
    logic          rd_en_x, rd_en_y, rd_en_local;
    logic          next_full;
    logic [WD-1:0] data_out;
    logic          wr_next_en;
    logic [2:0]    grant;
    logic          busy;
    logic [15:0]   flit_cnt;
    logic          stall_err;

    noc_out_port_arbiter #(.WD(WD), .DEST_CODE(DEST), .STALL_LIMIT(15)) dut (
        .wclk(wclk), .rst_n(rst_n),
        .empty_x(empty_x), .empty_y(empty_y), .empty_local(empty_local),
        .head_x(head_x), .head_y(head_y), .head_local(head_local),
        .rd_en_x(rd_en_x), .rd_en_y(rd_en_y), .rd_en_local(rd_en_local),
        .next_full(next_full), .data_out(data_out), .wr_next_en(wr_next_en),
        .grant(grant), .busy(busy), .flit_cnt(flit_cnt), .stall_err(stall_err)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Source FIFO contents
    logic [WD-1:0] qx[$];
    logic [WD-1:0] qy[$];
    logic [WD-1:0] ql[$];

    // Event logs (cycle numbers / values seen on the DUT)
    int            rd_cyc[$];
    int            g_log[$];
    int            wr_cyc[$];
    logic [WD-1:0] wr_dat[$];

    // Reference model state and predicted outputs
    int            m_ptr, m_stall;
    bit            m_send;
    logic [WD-1:0] e_data;
    logic [2:0]    e_rd;
    logic          e_wr, e_busy, e_err;
    logic [2:0]    e_grant;
    logic [15:0]   e_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int i);
        if (i == 0) return qx.size();
        if (i == 1) return qy.size();
        return ql.size();
    endfunction

    function automatic logic [WD-1:0] front(input int i);
        if (qsize(i) == 0) return '0;
        if (i == 0) return qx[0];
        if (i == 1) return qy[0];
        return ql[0];
    endfunction

    function automatic bit wants(input int i);
        logic [WD-1:0] f;
        f = front(i);
        return (qsize(i) > 0) && (f[WD-1:WD-4] == DEST);
    endfunction

    task automatic pop(input int i);
        if (qsize(i) > 0) begin
            if (i == 0) void'(qx.pop_front());
            else if (i == 1) void'(qy.pop_front());
            else void'(ql.pop_front());
        end
    endtask

    task automatic drive();
        empty_x     = (qx.size() == 0);
        empty_y     = (qy.size() == 0);
        empty_local = (ql.size() == 0);
        head_x      = front(0);
        head_y      = front(1);
        head_local  = front(2);
    endtask

    // Outputs expected after the coming clock edge.
    task automatic model_step();
        int w;
        if (!rst_n) begin
            e_data = '0; e_rd = '0; e_wr = 1'b0; e_grant = '0;
            e_busy = 1'b0; e_cnt = '0; e_err = 1'b0;
            m_ptr = 0; m_send = 1'b0; m_stall = 0;
        end else if (!m_send) begin
            e_wr = 1'b0;
            e_rd = '0;
            w = -1;
            for (int k = 0; k < 3; k++) begin
                if (w < 0 && wants((m_ptr + k) % 3)) w = (m_ptr + k) % 3;
            end
            if (w >= 0) begin
                e_data  = front(w);
                e_rd    = 3'(1 << w);
                e_grant = 3'(1 << w);
                e_busy  = 1'b1;
                m_send  = 1'b1;
                m_ptr   = (w + 1) % 3;
            end
        end else begin
            e_rd = '0;
            if (!next_full) begin
                e_wr = 1'b1; e_cnt = e_cnt + 16'd1; m_stall = 0;
                e_busy = 1'b0; m_send = 1'b0;
            end else begin
                e_wr = 1'b0;
                m_stall = (m_stall < 15) ? m_stall + 1 : 15;
                if (m_stall >= 15) e_err = 1'b1;
            end
        end
    endtask

    // One clock: predict, clock, compare, log, pop what the DUT read.
    task automatic cycle();
        logic [2:0] rd_now;
        drive();
        model_step();
        rd_now = {rd_en_local, rd_en_y, rd_en_x};
        @(posedge wclk);
        #1;
        cyc++;
        check("data_out",   64'(data_out),                           64'(e_data));
        check("rd_en",      64'({rd_en_local, rd_en_y, rd_en_x}),    64'(e_rd));
        check("wr_next_en", 64'(wr_next_en),                         64'(e_wr));
        check("grant",      64'(grant),                              64'(e_grant));
        check("busy",       64'(busy),                               64'(e_busy));
        check("flit_cnt",   64'(flit_cnt),                           64'(e_cnt));
        check("stall_err",  64'(stall_err),                          64'(e_err));
        if (rd_en_x || rd_en_y || rd_en_local) begin
            rd_cyc.push_back(cyc);
            g_log.push_back(int'(grant));
        end
        if (wr_next_en) begin
            wr_cyc.push_back(cyc);
            wr_dat.push_back(data_out);
        end
        for (int i = 0; i < 3; i++) begin
            if (rd_now[i] === 1'b1) pop(i);
        end
    endtask

    task automatic clear_logs();
        rd_cyc.delete(); g_log.delete(); wr_cyc.delete(); wr_dat.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic flush();
        qx.delete(); qy.delete(); ql.delete();
        next_full = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
    endtask

    function automatic logic [WD-1:0] flit(input logic [3:0] code, input logic [35:0] pay);
        return {code, pay};
    endfunction

    initial begin
        int t0;
        int cnt0;
        logic [WD-1:0] held;

        rst_n = 1'b0;
        next_full = 1'b0;
        drive();

        // Reset state
        do_reset();
        check("reset_cnt",   64'(flit_cnt),  64'd0);
        check("reset_grant", 64'(grant),     64'd0);

        // Single source, three flits back to back
        qx.push_back(40'h40_0000_0001);
        qx.push_back(40'h40_0000_0002);
        qx.push_back(40'h40_0000_0003);
        clear_logs();
        t0 = cyc;
        for (int i = 0; i < 8; i++) cycle();
        check("t1_rd_count", 64'(rd_cyc.size()), 64'd3);
        check("t1_wr_count", 64'(wr_cyc.size()), 64'd3);
        if (rd_cyc.size() == 3 && wr_cyc.size() == 3) begin
            check("t1_rd0", 64'(rd_cyc[0] - t0), 64'd1);
            check("t1_rd1", 64'(rd_cyc[1] - t0), 64'd3);
            check("t1_rd2", 64'(rd_cyc[2] - t0), 64'd5);
            check("t1_wr0", 64'(wr_cyc[0] - t0), 64'd2);
            check("t1_wr1", 64'(wr_cyc[1] - t0), 64'd4);
            check("t1_wr2", 64'(wr_cyc[2] - t0), 64'd6);
            check("t1_d0", 64'(wr_dat[0]), 64'h40_0000_0001);
            check("t1_d1", 64'(wr_dat[1]), 64'h40_0000_0002);
            check("t1_d2", 64'(wr_dat[2]), 64'h40_0000_0003);
        end
        check("t1_flit_cnt", 64'(flit_cnt), 64'd3);

        // All three sources request continuously: strict rotation
        do_reset();
        for (int i = 0; i < 6; i++) begin
            qx.push_back(flit(DEST, 36'(16'h100 + i)));
            qy.push_back(flit(DEST, 36'(16'h200 + i)));
            ql.push_back(flit(DEST, 36'(16'h300 + i)));
        end
        clear_logs();
        for (int i = 0; i < 13; i++) cycle();
        check("t2_grants", 64'(g_log.size()), 64'd7);
        for (int i = 0; i < 6 && i < g_log.size(); i++) begin
            check("t2_grant_seq", 64'(g_log[i]), 64'(1 << (i % 3)));
        end
        flush();

        // Non-matching x head is ignored, y still served
        qx.push_back(40'h80_0000_0001);
        qy.push_back(40'h40_0000_0005);
        clear_logs();
        for (int i = 0; i < 6; i++) cycle();
        check("t3_grants", 64'(g_log.size()), 64'd1);
        if (g_log.size() > 0) check("t3_grant_y", 64'(g_log[0]), 64'b010);
        if (wr_dat.size() > 0) check("t3_data", 64'(wr_dat[0]), 64'h40_0000_0005);
        check("t3_x_kept", 64'(qx.size()), 64'd1);
        flush();

        // Four cycles of backpressure in SEND
        qx.push_back(40'h40_0000_00aa);
        cnt0 = int'(flit_cnt);
        next_full = 1'b1;
        cycle();
        held = data_out;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t4_busy", 64'(busy), 64'd1);
            check("t4_no_wr", 64'(wr_next_en), 64'd0);
            check("t4_hold", 64'(data_out), 64'h40_0000_00aa);
        end
        next_full = 1'b0;
        cycle();
        check("t4_wr", 64'(wr_next_en), 64'd1);
        check("t4_cnt", 64'(flit_cnt), 64'(cnt0 + 1));
        check("t4_data", 64'(data_out), 64'(held));
        cycle();
        check("t4_single_wr", 64'(wr_next_en), 64'd0);

        // Twenty cycles of backpressure: watchdog fires after fifteen
        qy.push_back(40'h40_0000_00bb);
        next_full = 1'b1;
        cycle();
        for (int k = 1; k <= 20; k++) begin
            cycle();
            check("t5_stall_err", 64'(stall_err), 64'(k >= 15));
        end
        next_full = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check("t5_sticky", 64'(stall_err), 64'd1);

        // Reset in the middle of SEND
        do_reset();
        check("t6_err_cleared", 64'(stall_err), 64'd0);
        for (int i = 0; i < 2; i++) begin
            qx.push_back(flit(DEST, 36'(16'h700 + i)));
            qy.push_back(flit(DEST, 36'(16'h800 + i)));
            ql.push_back(flit(DEST, 36'(16'h900 + i)));
        end
        cycle();
        check("t6_send", 64'(busy), 64'd1);
        rst_n = 1'b0;
        cycle();
        check("t6_rst_outs", 64'({data_out, rd_en_x, rd_en_y, rd_en_local,
                                  wr_next_en, grant, busy, stall_err}), 64'd0);
        check("t6_rst_cnt", 64'(flit_cnt), 64'd0);
        rst_n = 1'b1;
        cycle();
        check("t6_grant_x", 64'(grant), 64'b001);
        check("t6_rd_x", 64'(rd_en_x), 64'd1);
        flush();

        // Randomized traffic with sporadic backpressure and foreign flits
        for (int n = 0; n < 400; n++) begin
            logic [3:0] code;
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(3) == 0 && qsize(i) < 4) begin
                    case ($urandom_range(3))
                        0: code = 4'b1000;
                        1: code = 4'b0010;
                        default: code = DEST;
                    endcase
                    if (i == 0) qx.push_back(flit(code, 36'($urandom)));
                    else if (i == 1) qy.push_back(flit(code, 36'($urandom)));
                    else ql.push_back(flit(code, 36'($urandom)));
                end
                // Another output port drains flits not meant for this one
                if (qsize(i) > 0 && !wants(i) && $urandom_range(2) == 0) pop(i);
            end
            next_full = ($urandom_range(9) < 3);
            cycle();
        end
        flush();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
